layer_index_fetch: RTL and testbench
====================================

# layer_index_fetch

Upstream stage of the color mapper. Converts the VGA controller's current pixel coordinate into ROM addresses for the two background layers (forest, 4-bit palette indices; area, 3-bit palette indices). Reads both synchronous ROMs and delivers `idx_forest` and `idx_area1`, pipeline-aligned with a delayed copy of DrawX/DrawY. Supports a per-frame horizontal scroll with parallax: the area layer scrolls at full rate and the forest layer at half rate. Scroll is latched only at frame start, so it never tears mid-frame.

## Interface
- `IMG_W`, default 640: width of both layer images in pixels. Scroll wraps modulo this value.
- `IMG_H`, default 480: height of both layer images. Rows at or above this value are invalid.
- `ADDR_W`, default 19: ROM address width. Must satisfy IMG_W*IMG_H ≤ 2^ADDR_W.

Ports:
- `Clk` in 1: pixel clock; all state on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse from the VGA controller at the start of vertical blanking.
- `scroll_we` in 1: write strobe for `scroll_dx`.
- `scroll_dx` in 10: requested horizontal scroll in pixels, 0..1023.
- `pix_valid` in 1: DrawX/DrawY is inside the active display.
- `DrawX`, `DrawY` in 10 each: current pixel coordinate.
- `forest_addr` out ADDR_W: forest ROM address.
- `forest_q` in 4: forest ROM data, one-cycle registered read.
- `area_addr` out ADDR_W: area ROM address.
- `area_q` in 3: area ROM data, one-cycle registered read.
- `idx_forest` out 4, `idx_area1` out 3: palette indices for the color mapper.
- `idx_valid` out 1: indices correspond to a valid pixel.
- `DrawX_o`, `DrawY_o` out 10 each: coordinate aligned with the indices.

## Operation
- **Scroll registers.** `pend_scroll` and `act_scroll` are 10 bits each, reset to 0.
  - `scroll_we` captures `scroll_dx` into `pend_scroll`. If `scroll_dx` ≥ IMG_W, IMG_W is subtracted once, so `pend_scroll` < IMG_W always.
  - `frame_start` copies `pend_scroll` into `act_scroll`.
  - If `scroll_we` and `frame_start` occur in the same cycle, `act_scroll` takes the new reduced `scroll_dx` (bypass), and `pend_scroll` is updated as well.
- **Address generation (stage A).**
  - `ax = DrawX + act_scroll`; if `ax` ≥ IMG_W, subtract IMG_W.
  - `fx = DrawX + (act_scroll >> 1)`; same single wrap.
  - `area_addr = DrawY*IMG_W + ax`; `forest_addr = DrawY*IMG_W + fx`. Intermediate sums are 11 bits; the product uses a constant multiply.
  - A pixel is valid when `pix_valid` = 1, DrawY < IMG_H and DrawX < IMG_W.
  - For an invalid pixel, both addresses are 0 and the stage-A valid bit is 0.
- **ROM stage.** The external ROM registers the address. Valid, DrawX and DrawY are carried one more stage alongside it.
- **Output stage (stage B).**
  - Valid pixel: `idx_forest <= forest_q`, `idx_area1 <= area_q`, `idx_valid <= 1`.
  - Invalid pixel: indices forced to 0, `idx_valid` = 0.
  - `DrawX_o` and `DrawY_o` are always passed through, whether the pixel is valid or not.
- Area index 3'd2 means "transparent, show forest". This block passes it through uninterpreted.
- The block has no stall or backpressure; it accepts a new coordinate every cycle.

## Timing
- **Reset.** While `Reset_n` = 0, all registers and outputs are 0: addresses, indices, `idx_valid`, `DrawX_o`/`DrawY_o`, both scroll registers. Assertion takes effect immediately, including mid-line; in-flight pixels are discarded.
- **Latency.** Coordinates sampled at edge N produce:
  - `forest_addr`/`area_addr` after edge N+1;
  - ROM data after edge N+2;
  - `idx_*`, `idx_valid`, `DrawX_o`, `DrawY_o` after edge N+3.
- Latency is a fixed 3 cycles with throughput of 1 pixel per cycle.
- **Scroll timing.** A `frame_start` pulse at edge F affects pixels sampled at edge F+1 and later. A `scroll_we` without `frame_start` never changes addresses within the current frame.
- **Wrap boundary.** With `act_scroll` = IMG_W−1 and DrawX = IMG_W−1, `ax` = IMG_W−2. Only a single subtraction is ever needed.

## Test plan
- **Reset.** Assert `Reset_n` = 0 mid-stream with `pix_valid` = 1. Required: every output reads 0 on the next sample, and the first valid index appears 3 cycles after release with valid input.
- **Basic fetch.** Scroll 0, DrawX=5, DrawY=2, `pix_valid` = 1.
  - Required: `area_addr` = `forest_addr` = 1285 after edge 1.
  - With the ROM model returning `area_q` = 3 and `forest_q` = 9: `idx_area1` = 3, `idx_forest` = 9, `idx_valid` = 1, `DrawX_o` = 5, `DrawY_o` = 2 after edge 3.
- **Deferred scroll.** Write `scroll_dx` = 100 with no `frame_start`. Required: addresses unchanged.
  - Then pulse `frame_start`, and drive DrawX=600, DrawY=0.
  - Required: `area_addr` = 60 (700−640) and `forest_addr` = 10 (650−640).
- **Simultaneous write and frame start.** `scroll_we` with `scroll_dx` = 200 in the same cycle as `frame_start`, then DrawX=0, DrawY=1. Required: `area_addr` = 840, `forest_addr` = 740.
- **Out-of-range scroll.** `scroll_dx` = 700, then `frame_start`, then DrawX=0, DrawY=0. Required: `area_addr` = 60 and `forest_addr` = 30.
- **Invalid pixels.**
  - DrawY=480 with `pix_valid` = 1: required addresses 0, and 3 cycles later `idx_valid` = 0 with both indices 0 even when the ROM model returns nonzero.
  - `pix_valid` = 0 at DrawX=100: same required response.

Source files
------------

// File: rtl/layer_index_fetch.sv
// Background-layer index fetch: turns the current pixel coordinate into forest/area ROM
// addresses with per-frame parallax scroll, and aligns the returned indices with DrawX/DrawY.
module layer_index_fetch #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              scroll_we,
  input  logic [9:0]        scroll_dx,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] forest_addr,
  input  logic [3:0]        forest_q,
  output logic [ADDR_W-1:0] area_addr,
  input  logic [2:0]        area_q,
  output logic [3:0]        idx_forest,
  output logic [2:0]        idx_area1,
  output logic              idx_valid,
  output logic [9:0]        DrawX_o,
  output logic [9:0]        DrawY_o
);

  localparam logic [9:0]        IMG_W_10 = 10'(IMG_W);
  localparam logic [10:0]       IMG_W_11 = 11'(IMG_W);
  localparam logic [9:0]        IMG_H_10 = 10'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

  // Requests may be up to 1023; a single subtraction keeps the scroll below IMG_W.
  function automatic logic [9:0] reduce_scroll(input logic [9:0] dx);
    logic [9:0] r;
    if (dx >= IMG_W_10) begin
      r = dx - IMG_W_10;
    end else begin
      r = dx;
    end
    return r;
  endfunction

  // Both operands are below IMG_W, so one wrap is always enough.
  function automatic logic [10:0] wrap_x(input logic [10:0] s);
    logic [10:0] r;
    if (s >= IMG_W_11) begin
      r = s - IMG_W_11;
    end else begin
      r = s;
    end
    return r;
  endfunction

  logic [9:0]        pend_scroll_r;
  logic [9:0]        act_scroll_r;
  logic [9:0]        dx_red_s;
  logic [9:0]        pend_next_s;
  logic [9:0]        act_next_s;

  logic [10:0]       ax_s;
  logic [10:0]       fx_s;
  logic              pix_ok_s;
  logic [ADDR_W-1:0] row_base_s;
  logic [ADDR_W-1:0] area_next_s;
  logic [ADDR_W-1:0] forest_next_s;

  logic              a_valid_r;
  logic [9:0]        a_x_r;
  logic [9:0]        a_y_r;
  logic              r_valid_r;
  logic [9:0]        r_x_r;
  logic [9:0]        r_y_r;

  logic [3:0]        idx_forest_next_s;
  logic [2:0]        idx_area_next_s;

  // Next-state for pending and active scroll; a write coinciding with frame start bypasses.
  always_comb begin
    dx_red_s    = reduce_scroll(scroll_dx);
    pend_next_s = pend_scroll_r;
    act_next_s  = act_scroll_r;
    if (scroll_we) begin
      pend_next_s = dx_red_s;
    end else begin
      pend_next_s = pend_scroll_r;
    end
    if (frame_start && scroll_we) begin
      act_next_s = dx_red_s;
    end else if (frame_start) begin
      act_next_s = pend_scroll_r;
    end else begin
      act_next_s = act_scroll_r;
    end
  end

  // Scroll registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_scroll_r <= 10'd0;
      act_scroll_r  <= 10'd0;
    end else begin
      pend_scroll_r <= pend_next_s;
      act_scroll_r  <= act_next_s;
    end
  end

  // Stage A address generation: area at full scroll, forest at half scroll.
  always_comb begin
    ax_s          = wrap_x({1'b0, DrawX} + {1'b0, act_scroll_r});
    fx_s          = wrap_x({1'b0, DrawX} + {2'b00, act_scroll_r[9:1]});
    pix_ok_s      = pix_valid && (DrawY < IMG_H_10) && (DrawX < IMG_W_10);
    row_base_s    = ADDR_W'(DrawY) * IMG_W_A;
    area_next_s   = {ADDR_W{1'b0}};
    forest_next_s = {ADDR_W{1'b0}};
    if (pix_ok_s) begin
      area_next_s   = row_base_s + ADDR_W'(ax_s);
      forest_next_s = row_base_s + ADDR_W'(fx_s);
    end else begin
      area_next_s   = {ADDR_W{1'b0}};
      forest_next_s = {ADDR_W{1'b0}};
    end
  end

  // Stage A register: ROM addresses plus the coordinate/valid that travel with them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      area_addr   <= {ADDR_W{1'b0}};
      forest_addr <= {ADDR_W{1'b0}};
      a_valid_r   <= 1'b0;
      a_x_r       <= 10'd0;
      a_y_r       <= 10'd0;
    end else begin
      area_addr   <= area_next_s;
      forest_addr <= forest_next_s;
      a_valid_r   <= pix_ok_s;
      a_x_r       <= DrawX;
      a_y_r       <= DrawY;
    end
  end

  // ROM stage: side-band follows the external ROM's own address register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid_r <= 1'b0;
      r_x_r     <= 10'd0;
      r_y_r     <= 10'd0;
    end else begin
      r_valid_r <= a_valid_r;
      r_x_r     <= a_x_r;
      r_y_r     <= a_y_r;
    end
  end

  // Stage B index selection; invalid pixels get zero indices regardless of ROM data.
  always_comb begin
    idx_forest_next_s = 4'd0;
    idx_area_next_s   = 3'd0;
    if (r_valid_r) begin
      idx_forest_next_s = forest_q;
      idx_area_next_s   = area_q;
    end else begin
      idx_forest_next_s = 4'd0;
      idx_area_next_s   = 3'd0;
    end
  end

  // Stage B output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_forest <= 4'd0;
      idx_area1  <= 3'd0;
      idx_valid  <= 1'b0;
      DrawX_o    <= 10'd0;
      DrawY_o    <= 10'd0;
    end else begin
      idx_forest <= idx_forest_next_s;
      idx_area1  <= idx_area_next_s;
      idx_valid  <= r_valid_r;
      DrawX_o    <= r_x_r;
      DrawY_o    <= r_y_r;
    end
  end

endmodule

// File: tb/tb_layer_index_fetch.sv
// Scoreboard bench for layer_index_fetch: directed vectors push expected addresses and indices,
// a monitor pops and compares them on the cycle they are due.
module tb_layer_index_fetch;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        scroll_we;
  logic [9:0]  scroll_dx;
  logic        pix_valid;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [18:0] forest_addr;
  logic [3:0]  forest_q;
  logic [18:0] area_addr;
  logic [2:0]  area_q;
  logic [3:0]  idx_forest;
  logic [2:0]  idx_area1;
  logic        idx_valid;
  logic [9:0]  draw_x_o;
  logic [9:0]  draw_y_o;

  layer_index_fetch #(.IMG_W(640), .IMG_H(480), .ADDR_W(19)) dut (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .scroll_we(scroll_we),
    .scroll_dx(scroll_dx), .pix_valid(pix_valid), .DrawX(draw_x), .DrawY(draw_y),
    .forest_addr(forest_addr), .forest_q(forest_q), .area_addr(area_addr), .area_q(area_q),
    .idx_forest(idx_forest), .idx_area1(idx_area1), .idx_valid(idx_valid),
    .DrawX_o(draw_x_o), .DrawY_o(draw_y_o)
  );

  typedef struct {
    int          at;
    logic [18:0] area;
    logic [18:0] forest;
    string       name;
  } addr_exp_t;

  typedef struct {
    int          at;
    logic [3:0]  fidx;
    logic [2:0]  aidx;
    logic        v;
    logic [9:0]  x;
    logic [9:0]  y;
    string       name;
  } idx_exp_t;

  addr_exp_t aq[$];
  idx_exp_t  iq[$];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // ROM contents: forest = addr[3:0]^0xC, area = addr[2:0]^0x6 (address 1285 gives 9 and 3)
  function automatic logic [3:0] rom_f(input logic [18:0] a);
    return a[3:0] ^ 4'hC;
  endfunction
  function automatic logic [2:0] rom_a(input logic [18:0] a);
    return a[2:0] ^ 3'h6;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    forest_q <= rom_f(forest_addr);
    area_q   <= rom_a(area_addr);
  end

  // Monitor: compares every expectation due on this cycle.
  always begin
    @(posedge clk);
    #2;
    while (aq.size() > 0 && aq[0].at <= cyc) begin
      addr_exp_t e;
      e = aq.pop_front();
      total++;
      if (e.at < cyc) begin
        bad++;
        $display("FAIL %s addr: expectation for cycle %0d never checked", e.name, e.at);
      end else if (area_addr !== e.area || forest_addr !== e.forest) begin
        bad++;
        $display("FAIL %s addr: got area=%0d forest=%0d, need area=%0d forest=%0d",
                 e.name, area_addr, forest_addr, e.area, e.forest);
      end
    end
    while (iq.size() > 0 && iq[0].at <= cyc) begin
      idx_exp_t e;
      e = iq.pop_front();
      total++;
      if (e.at < cyc) begin
        bad++;
        $display("FAIL %s idx: expectation for cycle %0d never checked", e.name, e.at);
      end else if (idx_forest !== e.fidx || idx_area1 !== e.aidx || idx_valid !== e.v ||
                   draw_x_o !== e.x || draw_y_o !== e.y) begin
        bad++;
        $display("FAIL %s idx: got f=%0d a=%0d v=%0d x=%0d y=%0d, need f=%0d a=%0d v=%0d x=%0d y=%0d",
                 e.name, idx_forest, idx_area1, idx_valid, draw_x_o, draw_y_o,
                 e.fidx, e.aidx, e.v, e.x, e.y);
      end
    end
  end

  // Drives one vector (no clock wait) and queues its address and index expectations.
  task automatic apply(input logic v, input int x, input int y, input logic fs, input logic we,
                       input int dx, input int ea, input int ef, input logic ev, input string nm);
    addr_exp_t a;
    idx_exp_t  i;
    logic [18:0] ea19;
    logic [18:0] ef19;
    ea19 = 19'(ea);
    ef19 = 19'(ef);
    pix_valid   = v;
    draw_x      = 10'(x);
    draw_y      = 10'(y);
    frame_start = fs;
    scroll_we   = we;
    scroll_dx   = 10'(dx);
    a.at = cyc + 1; a.area = ea19; a.forest = ef19; a.name = nm;
    aq.push_back(a);
    i.at = cyc + 3; i.v = ev; i.x = 10'(x); i.y = 10'(y); i.name = nm;
    i.fidx = ev ? rom_f(ef19) : 4'd0;
    i.aidx = ev ? rom_a(ea19) : 3'd0;
    iq.push_back(i);
  endtask

  task automatic drive(input logic v, input int x, input int y, input logic fs, input logic we,
                       input int dx, input int ea, input int ef, input logic ev, input string nm);
    @(negedge clk);
    apply(v, x, y, fs, we, dx, ea, ef, ev, nm);
  endtask

  task automatic push_zero_idx(input int at, input string nm);
    idx_exp_t i;
    i.at = at; i.fidx = 4'd0; i.aidx = 3'd0; i.v = 1'b0; i.x = 10'd0; i.y = 10'd0; i.name = nm;
    iq.push_back(i);
  endtask

  // Holds reset for one cycle; in-flight expectations are discarded with the pipeline.
  task automatic reset_step(input string nm);
    addr_exp_t a;
    @(negedge clk);
    rst_n       = 1'b0;
    frame_start = 1'b0;
    scroll_we   = 1'b0;
    aq.delete();
    iq.delete();
    a.at = cyc + 1; a.area = 19'd0; a.forest = 19'd0; a.name = nm;
    aq.push_back(a);
    push_zero_idx(cyc + 1, nm);
  endtask

  task automatic release_drive(input int x, input int y, input int ea, input int ef, input string nm);
    @(negedge clk);
    rst_n = 1'b1;
    push_zero_idx(cyc + 1, {nm, "_r1"});
    push_zero_idx(cyc + 2, {nm, "_r2"});
    apply(1'b1, x, y, 1'b0, 1'b0, 0, ea, ef, 1'b1, nm);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; scroll_we = 1'b0; scroll_dx = 10'd0;
    pix_valid = 1'b0; draw_x = 10'd0; draw_y = 10'd0;
    forest_q = 4'd0; area_q = 3'd0;

    repeat (3) reset_step("init_reset");
    release_drive(5, 2, 1285, 1285, "basic");
    drive(1'b0, 0, 0, 1'b0, 1'b1, 100, 0, 0, 1'b0, "write100");
    drive(1'b1, 5, 2, 1'b0, 1'b0, 0, 1285, 1285, 1'b1, "deferred_same");
    drive(1'b1, 600, 0, 1'b0, 1'b0, 0, 600, 600, 1'b1, "deferred_pre_fs");
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, "fs100");
    drive(1'b1, 600, 0, 1'b0, 1'b0, 0, 60, 10, 1'b1, "deferred");
    drive(1'b1, 639, 479, 1'b0, 1'b0, 0, 306659, 306609, 1'b1, "corner");
    drive(1'b0, 0, 0, 1'b1, 1'b1, 200, 0, 0, 1'b0, "fs_we200");
    drive(1'b1, 0, 1, 1'b0, 1'b0, 0, 840, 740, 1'b1, "bypass");
    drive(1'b0, 0, 0, 1'b0, 1'b1, 700, 0, 0, 1'b0, "write700");
    drive(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, "fs60");
    drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 60, 30, 1'b1, "oor_scroll");
    drive(1'b0, 0, 0, 1'b1, 1'b1, 639, 0, 0, 1'b0, "fs_we639");
    drive(1'b1, 639, 0, 1'b0, 1'b0, 0, 638, 318, 1'b1, "wrap_edge");
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1023, 0, 0, 1'b0, "fs_we1023");
    drive(1'b1, 639, 1, 1'b0, 1'b0, 0, 1022, 830, 1'b1, "max_scroll");
    drive(1'b1, 10, 480, 1'b0, 1'b0, 0, 0, 0, 1'b0, "row480");
    drive(1'b0, 100, 5, 1'b0, 1'b0, 0, 0, 0, 1'b0, "pix_invalid");
    drive(1'b1, 640, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0, "col640");
    drive(1'b1, 5, 2, 1'b0, 1'b0, 0, 1668, 1476, 1'b1, "scrolled");
    drive(1'b1, 7, 3, 1'b0, 1'b0, 0, 2310, 2118, 1'b1, "stream_a");
    drive(1'b1, 8, 3, 1'b0, 1'b0, 0, 2311, 2119, 1'b1, "stream_b");
    reset_step("mid_reset");
    reset_step("mid_reset_hold");
    release_drive(5, 2, 1285, 1285, "post_reset");
    drive(1'b1, 6, 2, 1'b0, 1'b0, 0, 1286, 1286, 1'b1, "post_reset_next");

    for (int k = 0; k < 10 && (aq.size() > 0 || iq.size() > 0); k++) @(posedge clk);
    #3;
    if (aq.size() > 0 || iq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d addr and %0d idx expectations left, need 0", aq.size(), iq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
